ext_sram_dma: RTL and testbench
===============================

Name: ext_sram_dma

Overview:
- Initiator/master for the external SRAM valid/ready interface: drives the R0 (read) and W0 (write) channels that the SRAM responder model serves.
- Performs word-granular copy (src→dst) or fill (constant→dst) of `len` 32-bit words.
- A small FIFO decouples the read and write channels, so the next read overlaps the current write.
- Sits between the core's control registers and the external SRAM port.

Parameters:
- ADDR_W, 26, word-address width of the R0/W0 channels and config addresses.
- DATA_W, 32, data width.
- FIFO_DEPTH, 2, read-to-write buffer entries (power of two, ≥2).
- TIMEOUT, 64, max cycles a valid may wait for ready before abort.

Ports:
- clk  in  1  single clock; all logic is posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin an operation; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src_addr  in  ADDR_W  first read word address (copy only).
- dst_addr  in  ADDR_W  first write word address.
- len  in  ADDR_W  number of words.
- fill_data  in  DATA_W  write value in fill mode.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag; cleared on accepted start.
- R0_clk  out  1  equals clk.
- R0_addr  out  ADDR_W  read address.
- R0_valid  out  1  read request.
- R0_data  in  DATA_W  read data, valid in the cycle R0_ready=1.
- R0_ready  in  1  read completion pulse.
- W0_clk  out  1  equals clk.
- W0_addr  out  ADDR_W  write address.
- W0_data  out  DATA_W  write data.
- W0_valid  out  1  write request.
- W0_ready  in  1  write completion pulse.

Behaviour:
- Reset (async, immediate): busy=0, done=0, err=0, R0_valid=0, W0_valid=0, R0_addr=0, W0_addr=0, W0_data=0; FIFO empty; all counters 0. Reset mid-operation abandons the transfer with no done pulse.
- Outputs: R0_*/W0_* valid, addr and data are registered. Addr and data stay stable for as long as the corresponding valid is high.
- Top FSM states: IDLE, RUN, FINISH.
  - IDLE→RUN on start. Latches src/dst/len/mode/fill_data, clears err, sets busy=1 on the next cycle.
  - start while busy is ignored.
  - len=0: IDLE→FINISH directly; no channel activity.
  - FINISH: done=1 and busy=0 for exactly one cycle, then IDLE.
- Handshake rule, each channel independently, sub-states REQ and GAP:
  - REQ: assert valid and hold it until ready is sampled 1.
  - On that edge: read captures R0_data into the FIFO; write pops the FIFO.
  - Next cycle is GAP with valid=0. Valid is never high on the cycle immediately after an accepted ready, because the responder re-arms on a held valid.
- Read channel (copy mode only):
  - Issues read i at src_addr+i while reads_issued<len and the FIFO has a free slot. A slot is counted free from the cycle its pop occurs.
  - Fill mode never asserts R0_valid.
- Write channel:
  - Issues write i at dst_addr+i with FIFO head data (copy) or latched fill_data (fill), whenever data is available.
  - Writes complete strictly in order.
  - RUN→FINISH on the cycle writes_done reaches len.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Addresses increment modulo 2^ADDR_W: 0x3FFFFFF+1 → 0x0000000.
- Overlapping src/dst ranges are not handled; results are undefined.
- Timeout:
  - A per-channel counter runs while valid=1 and ready=0.
  - On reaching TIMEOUT: err=1, both valids drop next cycle, FIFO flushes, FSM→FINISH (done pulses with err=1).
- R0_ready/W0_ready arriving while the matching valid=0 is ignored.

Test Plan:
- Copy, len=4, src=0x100 preloaded with 0xA0..0xA3, dst=0x200, responder latencies 2/2 → 0x200..0x203 read back 0xA0..0xA3. Exactly one done pulse, err=0. Every valid drops for ≥1 cycle after each ready.
- Fill, len=3, dst=0x3FFFFFE, fill_data=0xDEADBEEF → words at 0x3FFFFFE, 0x3FFFFFF, 0x0000000 = 0xDEADBEEF. R0_valid never asserted.
- len=0 start → done pulses within 2 cycles. R0_valid and W0_valid stay 0; busy never asserted during the pulse.
- Copy len=8 with write latency 6, read latency 0 → FIFO occupancy never exceeds 2. Reads stall while full; data order preserved at dst.
- Responder ready tied 0, TIMEOUT=64 → err=1, done pulses after 64 wait cycles, valids 0. Next start clears err.
- rst_n asserted during copy len=16 → outputs 0 asynchronously, no done. A new copy after reset completes correctly.

Source files
------------

// File: rtl/ext_sram_dma.sv
// ext_sram_dma: word copy/fill engine mastering the external SRAM R0/W0 ports.
// A small FIFO lets the next read overlap the write still in flight.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, mode           begin request (IDLE only), 0=copy 1=fill
//   src_addr, dst_addr    first read / write word address
//   len, fill_data        word count, constant for fill mode
//   busy, done, err       in progress, 1-cycle completion, sticky timeout
//   R0_*                  read channel (clk, addr, valid out; data, ready in)
//   W0_*                  write channel (clk, addr, data, valid out; ready in)
module ext_sram_dma #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              R0_clk,
    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_valid,
    input  logic [DATA_W-1:0] R0_data,
    input  logic              R0_ready,
    output logic              W0_clk,
    output logic [ADDR_W-1:0] W0_addr,
    output logic [DATA_W-1:0] W0_data,
    output logic              W0_valid,
    input  logic              W0_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t state_q, state_d;

    logic              mode_q;
    logic [ADDR_W-1:0] len_q;
    logic [DATA_W-1:0] fill_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_cnt_q;
    logic [ADDR_W-1:0] wi_cnt_q;
    logic [ADDR_W-1:0] wd_cnt_q;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  fifo_wp_q;
    logic [PTR_W-1:0]  fifo_rp_q;
    logic [CNT_W-1:0]  fifo_cnt_q;

    logic [TO_W-1:0]   rd_to_q;
    logic [TO_W-1:0]   wr_to_q;

    logic run;
    logic rd_acc;
    logic wr_acc;
    logic rd_to_hit;
    logic wr_to_hit;
    logic abort;
    logic wr_last;
    logic fifo_room;
    logic wr_avail;
    logic rd_issue;
    logic wr_issue;
    logic push;
    logic pop;

    assign R0_clk = clk;
    assign W0_clk = clk;

    assign run    = (state_q == S_RUN);
    assign rd_acc = R0_valid && R0_ready;
    assign wr_acc = W0_valid && W0_ready;

    // The wait counter holds TIMEOUT-1 on the TIMEOUT-th stalled cycle.
    assign rd_to_hit = R0_valid && !R0_ready
                    && (rd_to_q == TO_W'(TIMEOUT - 1));
    assign wr_to_hit = W0_valid && !W0_ready
                    && (wr_to_q == TO_W'(TIMEOUT - 1));
    assign abort     = run && (rd_to_hit || wr_to_hit);

    assign wr_last = wr_acc && ((wd_cnt_q + ADDR_W'(1)) == len_q);

    // A slot popped on this edge is already usable by the next read.
    assign fifo_room = (fifo_cnt_q != CNT_W'(FIFO_DEPTH)) || wr_acc;

    // Only one request per channel is ever outstanding, so an idle
    // valid means the FIFO head is not owned by any in-flight write.
    assign wr_avail = mode_q ? (wi_cnt_q != len_q)
                             : (fifo_cnt_q != '0);

    assign rd_issue = run && !abort && !mode_q && !R0_valid
                   && (rd_cnt_q != len_q) && fifo_room;
    assign wr_issue = run && !abort && !W0_valid && wr_avail;

    assign push = run && !abort && rd_acc;
    assign pop  = run && !abort && wr_acc && !mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (abort || wr_last) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wp_q] <= R0_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err        <= 1'b0;
            R0_valid   <= 1'b0;
            R0_addr    <= '0;
            W0_valid   <= 1'b0;
            W0_addr    <= '0;
            W0_data    <= '0;
            mode_q     <= 1'b0;
            len_q      <= '0;
            fill_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            wi_cnt_q   <= '0;
            wd_cnt_q   <= '0;
            fifo_wp_q  <= '0;
            fifo_rp_q  <= '0;
            fifo_cnt_q <= '0;
            rd_to_q    <= '0;
            wr_to_q    <= '0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                err        <= 1'b0;
                mode_q     <= mode;
                len_q      <= len;
                fill_q     <= fill_data;
                rd_ptr_q   <= src_addr;
                wr_ptr_q   <= dst_addr;
                rd_cnt_q   <= '0;
                wi_cnt_q   <= '0;
                wd_cnt_q   <= '0;
                fifo_wp_q  <= '0;
                fifo_rp_q  <= '0;
                fifo_cnt_q <= '0;
            end
            rd_to_q <= '0;
            wr_to_q <= '0;
        end else if (abort) begin
            err        <= 1'b1;
            R0_valid   <= 1'b0;
            W0_valid   <= 1'b0;
            fifo_wp_q  <= '0;
            fifo_rp_q  <= '0;
            fifo_cnt_q <= '0;
            rd_to_q    <= '0;
            wr_to_q    <= '0;
        end else if (run) begin
            if (rd_issue) begin
                R0_valid <= 1'b1;
                R0_addr  <= rd_ptr_q;
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                rd_cnt_q <= rd_cnt_q + ADDR_W'(1);
            end else if (rd_acc) begin
                R0_valid <= 1'b0;
            end

            if (wr_issue) begin
                W0_valid <= 1'b1;
                W0_addr  <= wr_ptr_q;
                W0_data  <= mode_q ? fill_q : fifo_mem[fifo_rp_q];
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                wi_cnt_q <= wi_cnt_q + ADDR_W'(1);
            end else if (wr_acc) begin
                W0_valid <= 1'b0;
                wd_cnt_q <= wd_cnt_q + ADDR_W'(1);
            end

            if (push) begin
                fifo_wp_q <= fifo_wp_q + PTR_W'(1);
            end
            if (pop) begin
                fifo_rp_q <= fifo_rp_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase

            rd_to_q <= (R0_valid && !R0_ready) ? rd_to_q + TO_W'(1) : '0;
            wr_to_q <= (W0_valid && !W0_ready) ? wr_to_q + TO_W'(1) : '0;
        end else begin
            rd_to_q <= '0;
            wr_to_q <= '0;
        end
    end

endmodule

// File: tb/tb_ext_sram_dma.sv
// Bench for ext_sram_dma: SRAM responder model on R0/W0 plus a write
// scoreboard filled when each operation is launched.
module tb_ext_sram_dma;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [25:0] src_addr;
    logic [25:0] dst_addr;
    logic [25:0] len;
    logic [31:0] fill_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        R0_clk;
    logic [25:0] R0_addr;
    logic        R0_valid;
    logic [31:0] R0_data;
    logic        R0_ready;
    logic        W0_clk;
    logic [25:0] W0_addr;
    logic [31:0] W0_data;
    logic        W0_valid;
    logic        W0_ready;

    ext_sram_dma dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_data (fill_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .R0_clk    (R0_clk),
        .R0_addr   (R0_addr),
        .R0_valid  (R0_valid),
        .R0_data   (R0_data),
        .R0_ready  (R0_ready),
        .W0_clk    (W0_clk),
        .W0_addr   (W0_addr),
        .W0_data   (W0_data),
        .W0_valid  (W0_valid),
        .W0_ready  (W0_ready)
    );

    typedef struct packed {
        logic [25:0] a;
        logic [31:0] d;
    } wr_t;

    bit [31:0] mem [bit [25:0]];
    wr_t       sb [$];

    int checks;
    int failures;
    int rlat;
    int wlat;
    bit rstall;
    bit wstall;
    int done_cnt;
    int rv_cycles;
    int rd_acc_n;
    int wr_acc_n;
    int max_occ;
    bit r0_seen;
    bit w0_seen;
    bit bsy_seen;
    bit busy_in_done;
    bit r_armed;
    bit w_armed;
    int r_cnt;
    int w_cnt;
    logic done_err;
    logic done_rv;
    logic done_wv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SRAM responder + monitors, evaluated on the falling edge.
    initial begin
        R0_ready = 1'b0;
        W0_ready = 1'b0;
        R0_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                R0_ready = 1'b0;
                W0_ready = 1'b0;
                r_armed  = 1'b0;
                w_armed  = 1'b0;
            end else begin
                if (done) begin
                    done_cnt++;
                    if (busy) busy_in_done = 1'b1;
                end
                if (busy) bsy_seen = 1'b1;
                if (R0_valid) begin
                    r0_seen = 1'b1;
                    rv_cycles++;
                end
                if (W0_valid) w0_seen = 1'b1;

                if (R0_ready) begin
                    R0_ready = 1'b0;
                    r_armed  = 1'b0;
                    check("r_gap", {63'd0, R0_valid}, 64'd0);
                end else if (!R0_valid) begin
                    r_armed = 1'b0;
                end else begin
                    if (!r_armed) begin
                        r_armed = 1'b1;
                        r_cnt   = 0;
                    end else begin
                        r_cnt++;
                    end
                    if (!rstall && r_cnt >= rlat) begin
                        R0_ready = 1'b1;
                        R0_data  = mem.exists(R0_addr) ? mem[R0_addr] : 32'd0;
                        rd_acc_n++;
                    end
                end

                if (W0_ready) begin
                    W0_ready = 1'b0;
                    w_armed  = 1'b0;
                    check("w_gap", {63'd0, W0_valid}, 64'd0);
                end else if (!W0_valid) begin
                    w_armed = 1'b0;
                end else begin
                    if (!w_armed) begin
                        w_armed = 1'b1;
                        w_cnt   = 0;
                    end else begin
                        w_cnt++;
                    end
                    if (!wstall && w_cnt >= wlat) begin
                        W0_ready = 1'b1;
                        mem[W0_addr] = W0_data;
                        wr_acc_n++;
                        if (sb.size() == 0) begin
                            check("sb_extra_write", {38'd0, W0_addr}, 64'd0);
                            check("sb_extra_count", 64'd1, 64'd0);
                        end else begin
                            wr_t e;
                            e = sb.pop_front();
                            check("wr_addr", {38'd0, W0_addr}, {38'd0, e.a});
                            check("wr_data", {32'd0, W0_data}, {32'd0, e.d});
                        end
                    end
                end

                if (rd_acc_n - wr_acc_n > max_occ) max_occ = rd_acc_n - wr_acc_n;
            end
        end
    end

    task automatic push_copy(input logic [25:0] s, input logic [25:0] d,
                             input int n);
        for (int i = 0; i < n; i++) begin
            logic [25:0] sa;
            logic [25:0] da;
            sa = s + 26'(i);
            da = d + 26'(i);
            sb.push_back('{a: da, d: mem[sa]});
        end
    endtask

    task automatic push_fill(input logic [25:0] d, input int n,
                             input logic [31:0] v);
        for (int i = 0; i < n; i++) begin
            logic [25:0] da;
            da = d + 26'(i);
            sb.push_back('{a: da, d: v});
        end
    endtask

    task automatic clear_mon();
        rv_cycles    = 0;
        r0_seen      = 1'b0;
        w0_seen      = 1'b0;
        bsy_seen     = 1'b0;
        busy_in_done = 1'b0;
        rd_acc_n     = 0;
        wr_acc_n     = 0;
        max_occ      = 0;
    endtask

    task automatic run_op(input string tag, input logic m,
                          input logic [25:0] s, input logic [25:0] d,
                          input logic [25:0] n, input logic [31:0] f,
                          output int cyc);
        int base;
        @(negedge clk);
        mode      = m;
        src_addr  = s;
        dst_addr  = d;
        len       = n;
        fill_data = f;
        start     = 1'b1;
        base      = done_cnt;
        @(negedge clk);
        start = 1'b0;
        #1;
        cyc = 1;
        while (done_cnt == base && cyc < 3000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check({tag, "_done_seen"}, {63'd0, done_cnt != base}, 64'd1);
        done_err = err;
        done_rv  = R0_valid;
        done_wv  = W0_valid;
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_done_once"}, 64'(done_cnt - base), 64'd1);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int cyc;
        int base;
        checks    = 0;
        failures  = 0;
        done_cnt  = 0;
        rlat      = 2;
        wlat      = 2;
        rstall    = 1'b0;
        wstall    = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        len       = '0;
        fill_data = '0;
        clear_mon();

        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_r0v", {63'd0, R0_valid}, 64'd0);
        check("rst_w0v", {63'd0, W0_valid}, 64'd0);
        check("rst_r0a", {38'd0, R0_addr}, 64'd0);
        check("rst_w0a", {38'd0, W0_addr}, 64'd0);
        check("rst_w0d", {32'd0, W0_data}, 64'd0);
        #1 rst_n = 1'b1;

        // Copy of four words, 2/2 latency.
        for (int i = 0; i < 4; i++) mem[26'h100 + 26'(i)] = 32'hA0 + 32'(i);
        push_copy(26'h100, 26'h200, 4);
        clear_mon();
        run_op("copy4", 1'b0, 26'h100, 26'h200, 26'd4, 32'd0, cyc);
        check("copy4_err", {63'd0, done_err}, 64'd0);
        for (int i = 0; i < 4; i++)
            check("copy4_mem", {32'd0, mem[26'h200 + 26'(i)]}, 64'hA0 + 64'(i));

        // Fill across the top of the address space.
        push_fill(26'h3FFFFFE, 3, 32'hDEADBEEF);
        clear_mon();
        run_op("fill3", 1'b1, 26'h0, 26'h3FFFFFE, 26'd3, 32'hDEADBEEF, cyc);
        check("fill3_r0_seen", {63'd0, r0_seen}, 64'd0);
        check("fill3_wrap_mem", {32'd0, mem[26'h0]}, 64'hDEADBEEF);

        // Zero-length request.
        clear_mon();
        run_op("len0", 1'b0, 26'h10, 26'h20, 26'd0, 32'd0, cyc);
        check("len0_lat", {63'd0, cyc <= 2}, 64'd1);
        check("len0_r0", {63'd0, r0_seen}, 64'd0);
        check("len0_w0", {63'd0, w0_seen}, 64'd0);
        check("len0_busy", {63'd0, bsy_seen | busy_in_done}, 64'd0);

        // Slow writer, fast reader: FIFO fills to depth and reads stall.
        rlat = 0;
        wlat = 6;
        for (int i = 0; i < 8; i++) mem[26'h300 + 26'(i)] = $urandom;
        push_copy(26'h300, 26'h400, 8);
        clear_mon();
        run_op("copy8", 1'b0, 26'h300, 26'h400, 26'd8, 32'd0, cyc);
        check("copy8_occ", 64'(max_occ), 64'd2);
        check("copy8_busy_done", {63'd0, busy_in_done}, 64'd0);

        // Responder never answers: abort after TIMEOUT waits.
        rlat   = 1;
        wlat   = 1;
        rstall = 1'b1;
        wstall = 1'b1;
        clear_mon();
        run_op("tmo", 1'b0, 26'h900, 26'hA00, 26'd2, 32'd0, cyc);
        check("tmo_err", {63'd0, done_err}, 64'd1);
        check("tmo_wait", 64'(rv_cycles), 64'd64);
        check("tmo_r0v", {63'd0, done_rv}, 64'd0);
        check("tmo_w0v", {63'd0, done_wv}, 64'd0);
        check("tmo_err_sticky", {63'd0, err}, 64'd1);
        rstall = 1'b0;
        wstall = 1'b0;
        push_fill(26'h50, 1, 32'h1234);
        clear_mon();
        run_op("after_tmo", 1'b1, 26'h0, 26'h50, 26'd1, 32'h1234, cyc);
        check("after_tmo_err", {63'd0, done_err}, 64'd0);

        // Reset in the middle of a long copy.
        for (int i = 0; i < 16; i++) mem[26'h500 + 26'(i)] = 32'h5500 + 32'(i);
        push_copy(26'h500, 26'h600, 16);
        clear_mon();
        @(negedge clk);
        mode     = 1'b0;
        src_addr = 26'h500;
        dst_addr = 26'h600;
        len      = 26'd16;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("mid_busy", {63'd0, busy}, 64'd1);
        base = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_r0v", {63'd0, R0_valid}, 64'd0);
        check("arst_w0v", {63'd0, W0_valid}, 64'd0);
        check("arst_r0a", {38'd0, R0_addr}, 64'd0);
        check("arst_w0a", {38'd0, W0_addr}, 64'd0);
        check("arst_w0d", {32'd0, W0_data}, 64'd0);
        repeat (3) @(negedge clk);
        #2;
        sb.delete();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("arst_no_done", 64'(done_cnt - base), 64'd0);
        check("arst_idle", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 4; i++) mem[26'h700 + 26'(i)] = 32'h7700 + 32'(i);
        push_copy(26'h700, 26'h800, 4);
        clear_mon();
        run_op("post_rst", 1'b0, 26'h700, 26'h800, 26'd4, 32'd0, cyc);
        check("post_rst_err", {63'd0, done_err}, 64'd0);
        check("post_rst_mem", {32'd0, mem[26'h803]}, 64'h7703);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
